mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 195 +++++++++++++++++++
 tb/tb_mem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-outstanding memory responder with configurable
//               response latency and byte-lane write enables.
//               A request is accepted in IDLE, the FSM waits out the latency
//               in WAIT, and the response is held in RESP until it is
//               consumed. Storage is a flat array of XLEN-bit words and is
//               not cleared by reset.
//
// Parameters  : XLEN        - data/address width in bits (multiple of 8)
//               DEPTH_WORDS - number of XLEN-bit storage words (>= 2)
//               LATENCY     - cycles from acceptance to rsp_valid_o (1..15)
//
// Ports       : clk_i        in   clock, rising edge
//               rst_i        in   asynchronous active-high reset
//               req_valid_i  in   request present
//               req_ready_o  out  request can be accepted (IDLE only)
//               req_we_i     in   1 = write, 0 = read
//               req_addr_i   in   byte address
//               req_wdata_i  in   write data
//               req_be_i     in   byte-lane write enables
//               rsp_valid_o  out  response present (RESP only)
//               rsp_ready_i  in   response consumed
//               rsp_rdata_o  out  read data (0 for writes and faults)
//               rsp_err_o    out  request faulted
//
// Build macro : MEM_ALIGN_CHECK_EN - when defined, addresses with
//               addr[1:0] != 0 fault like out-of-range accesses; otherwise
//               the low two address bits are ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [XLEN-1:0]     req_addr_i,
    input  logic [XLEN-1:0]     req_wdata_i,
    input  logic [XLEN/8-1:0]   req_be_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [XLEN-1:0]     rsp_rdata_o,
    output logic                rsp_err_o
);

    localparam int              c_IDX_W   = $clog2(DEPTH_WORDS);
    localparam int              c_NBYTES  = XLEN / 8;
    localparam logic [3:0]      c_LAT_M1  = 4'(LATENCY - 1);
    localparam bit              c_LAT_ONE = (LATENCY == 1);
    localparam logic [XLEN-1:0] c_DEPTH   = XLEN'(DEPTH_WORDS);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    logic [1:0]          r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [XLEN-1:0]     r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic [c_NBYTES-1:0] r_be;
    logic [XLEN-1:0]     r_rdata;
    logic                r_err;

    logic [XLEN-1:0]     r_mem [DEPTH_WORDS];

    logic                w_in_idle;
    logic                w_accept;
    logic                w_enter_resp;
    logic                w_we;
    logic [XLEN-1:0]     w_addr;
    logic [XLEN-1:0]     w_wdata;
    logic [c_NBYTES-1:0] w_be;
    logic [XLEN-1:0]     w_word;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_oor;
    logic                w_misalign;
    logic                w_fault;
    logic                w_mem_we;

    assign w_in_idle   = (r_state == c_S_IDLE);
    // Ready is held low while reset is asserted so nothing is accepted
    // until the reset has been released.
    assign req_ready_o = w_in_idle && !rst_i;
    assign w_accept    = req_valid_i && req_ready_o;
    assign rsp_valid_o = (r_state == c_S_RESP);
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

    // With LATENCY = 1 the response is produced on the acceptance edge
    // itself, so the live request fields must be used while in IDLE;
    // otherwise the latched copies are used.
    assign w_we    = w_in_idle ? req_we_i    : r_we;
    assign w_addr  = w_in_idle ? req_addr_i  : r_addr;
    assign w_wdata = w_in_idle ? req_wdata_i : r_wdata;
    assign w_be    = w_in_idle ? req_be_i    : r_be;

    assign w_enter_resp = (c_LAT_ONE && w_accept) ||
                          ((r_state == c_S_WAIT) && (r_cnt == 4'd1));

    // Range check uses the full word address so that aliases above the
    // array (e.g. 4*DEPTH_WORDS) fault instead of wrapping onto word 0.
    assign w_word = {2'b00, w_addr[XLEN-1:2]};
    assign w_idx  = w_addr[c_IDX_W+1:2];
    assign w_oor  = (w_word >= c_DEPTH);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = |w_addr[1:0];
`else
    logic w_unused_addr_lsb;
    assign w_misalign        = 1'b0;
    assign w_unused_addr_lsb = &{1'b0, w_addr[1:0]};
`endif

    assign w_fault  = w_oor || w_misalign;
    assign w_mem_we = w_enter_resp && w_we && !w_fault && !rst_i;

    // Storage: never reset, byte lanes written individually.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_NBYTES; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Control FSM and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we_i;
                        r_addr  <= req_addr_i;
                        r_wdata <= req_wdata_i;
                        r_be    <= req_be_i;
                        if (c_LAT_ONE) begin
                            r_state <= c_S_RESP;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_state <= c_S_WAIT;
                            r_cnt   <= c_LAT_M1;
                        end
                    end
                end
                c_S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= c_S_RESP;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state <= c_S_IDLE;
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase

            // Response capture happens on the edge entering RESP; the
            // registers then hold steady for the whole RESP period.
            if (w_enter_resp) begin
                r_err   <= w_fault;
                r_rdata <= (!w_we && !w_fault) ? r_mem[w_idx] : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder (XLEN=32,
//               DEPTH_WORDS=1024, LATENCY=2). A table of request vectors
//               with hand-computed responses is applied in a loop, followed
//               by hand-written reset-abort and reset-in-RESP sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int XLEN        = 32;
    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [XLEN-1:0]   req_addr_i;
    logic [XLEN-1:0]   req_wdata_i;
    logic [XLEN/8-1:0] req_be_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [XLEN-1:0]   rsp_rdata_o;
    logic              rsp_err_o;

    int checks = 0;
    int errors = 0;

    mem_responder #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full request/response transaction. Latency is counted in clock
    // edges starting with the accepting edge.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 20) chk({tag, "_ready_timeout"}, 32'(n), 32'd0);
        @(posedge clk_i);
        #1;
        // Scramble request fields; the DUT must use the latched copies.
        req_valid_i = 1'b0;
        req_we_i    = ~we;
        req_addr_i  = 32'hFFFF_FFFC;
        req_wdata_i = 32'h5A5A_5A5A;
        req_be_i    = 4'hF;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        if (!rsp_valid_o) chk({tag, "_rsp_timeout"}, 32'(rsp_valid_o), 32'd1);
        rdata = rsp_rdata_o;
        err   = rsp_err_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("%s_hold%0d_valid", tag, i), 32'(rsp_valid_o), 32'd1);
            chk($sformatf("%s_hold%0d_rdata", tag, i), rsp_rdata_o, rdata);
            chk($sformatf("%s_hold%0d_err", tag, i), 32'(rsp_err_o), 32'(err));
            chk($sformatf("%s_hold%0d_ready", tag, i), 32'(req_ready_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        chk({tag, "_post_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_post_ready"}, 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        seen;

        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_be_i    = '0;
        rsp_ready_i = 1'b0;

        //           we    addr          wdata         be    hold exp_rdata     err
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 5, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 32'h11BB_33DD, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 32'h11BB_33DD, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 32'h0000_0FFC, 32'h0BAD_CAFE, 4'hF, 0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,         4'h0, 3, 32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 0, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 32'h1234_5678, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 0, 32'h0BAD_CAFE, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 32'h11BB_33DD, 1'b0});
`ifdef MEM_ALIGN_CHECK_EN
        vecs.push_back('{1'b0, 32'h0000_0012, 32'h0,         4'h0, 0, 32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h0000_0011, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         1'b1});
`else
        vecs.push_back('{1'b0, 32'h0000_0012, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0011, 32'hFFFF_FFFF, 4'h0, 0, 32'h0,         1'b0});
`endif
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0030, 32'h0000_0000, 4'hF, 0, 32'h0,         1'b0});

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_err", 32'(rsp_err_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_release_ready", 32'(req_ready_o), 32'd1);
        chk("rst_release_valid", 32'(rsp_valid_o), 32'd0);

        // Table-driven vectors
        foreach (vecs[k]) begin
            txn($sformatf("v%0d", k), vecs[k].we, vecs[k].addr, vecs[k].wdata,
                vecs[k].be, vecs[k].hold, rd, er, lat);
            chk($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rdata);
            chk($sformatf("v%0d_err", k), 32'(er), 32'(vecs[k].exp_err));
            chk($sformatf("v%0d_latency", k), 32'(lat), 32'(LATENCY));
        end

        // Reset asserted in WAIT during a write to 0x30 aborts it.
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h0000_0030;
        req_wdata_i = 32'h7777_7777;
        req_be_i    = 4'hF;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        chk("abort_in_wait_ready", 32'(req_ready_o), 32'd0);
        rst_i = 1'b1;
        #1;
        seen = rsp_valid_o;
        repeat (2) begin
            @(posedge clk_i);
            #1;
            seen = seen | rsp_valid_o;
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (4) begin
            @(posedge clk_i);
            #1;
            seen = seen | rsp_valid_o;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        chk("abort_ready", 32'(req_ready_o), 32'd1);
        txn("abort_rd", 1'b0, 32'h0000_0030, 32'h0, 4'h0, 0, rd, er, lat);
        chk("abort_rd_rdata", rd, 32'h0);
        chk("abort_rd_err", 32'(er), 32'd0);

        // Reset asserted in RESP drops the response.
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h0000_0010;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("resp_rst_pre_valid", 32'(rsp_valid_o), 32'd1);
        chk("resp_rst_pre_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
        rst_i = 1'b1;
        #1;
        chk("resp_rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("resp_rst_rdata", rsp_rdata_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("resp_rst_ready", 32'(req_ready_o), 32'd1);
        txn("post_rst_rd", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, rd, er, lat);
        chk("post_rst_rd_rdata", rd, 32'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
